// File: rtl/ram_yanitlayici.sv
// Line-wide RAM responder: in-order request FIFO, BOS/YAZIYOR pop FSM, fixed-latency read pipeline.
// Read response OKU_GECIKME edges after push into an idle queue; ram_mesgul_c raised one entry before full.

module ram_yanitlayici_fifo #(
   parameter int GEN = 8,
   parameter int DER = 4
) (
   input  logic                       clk_g,
   input  logic                       resetn,
   input  logic                       push,
   input  logic                       pop,
   input  logic [GEN-1:0]             giris,
   output logic [GEN-1:0]             cikis,
   output logic [$clog2(DER+1)-1:0]   sayi
);
   localparam int IW = (DER > 1) ? $clog2(DER) : 1;
   localparam int CW = $clog2(DER+1);

   logic [GEN-1:0] hafiza [DER];
   logic [IW-1:0]  yaz_ptr;
   logic [IW-1:0]  oku_ptr;

   always_ff @(posedge clk_g) begin
      if (push) hafiza[yaz_ptr] <= giris;
   end

   always_ff @(posedge clk_g) begin
      if (!resetn) begin
         yaz_ptr <= '0;
         oku_ptr <= '0;
         sayi    <= '0;
      end else begin
         if (push) yaz_ptr <= (yaz_ptr == IW'(DER-1)) ? '0 : yaz_ptr + IW'(1);
         if (pop)  oku_ptr <= (oku_ptr == IW'(DER-1)) ? '0 : oku_ptr + IW'(1);
         sayi <= sayi + CW'(push) - CW'(pop);
      end
   end

   assign cikis = hafiza[oku_ptr];
endmodule

module ram_yanitlayici #(
   parameter int ADRES_BIT      = 32,
   parameter int VO_VERI_BIT    = 128,
   parameter int SATIR_KAYDIRMA = 7,
   parameter int DERINLIK       = 256,
   parameter int OKU_GECIKME    = 2,
   parameter int YAZ_GECIKME    = 3,
   parameter int FIFO_DERINLIK  = 4
) (
   input  logic                   clk_g,
   input  logic                   resetn,
   input  logic [ADRES_BIT-1:0]   ram_adres_g,
   input  logic                   ram_oku_gecerli_g,
   input  logic                   ram_yaz_gecerli_g,
   input  logic [VO_VERI_BIT-1:0] ram_yaz_veri_g,
   output logic [VO_VERI_BIT-1:0] ram_oku_veri_c,
   output logic [ADRES_BIT-1:0]   ram_oku_adres_c,
   output logic                   ram_oku_gecerli_c,
   output logic                   ram_mesgul_c,
   output logic                   hata_c
);
   localparam int SW = ADRES_BIT - SATIR_KAYDIRMA;
   localparam int DW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
   localparam int CW = $clog2(FIFO_DERINLIK+1);
   localparam int KW = (YAZ_GECIKME > 1) ? $clog2(YAZ_GECIKME) : 1;

   typedef struct packed {
      logic                   yaz;
      logic [ADRES_BIT-1:0]   adres;
      logic [VO_VERI_BIT-1:0] veri;
   } istek_t;

   typedef enum logic {BOS, YAZIYOR} durum_t;

   istek_t                 yeni;
   istek_t                 bas;
   logic [CW-1:0]          sayi;
   logic [CW-1:0]          sayi_sonraki;
   logic                   istek;
   logic                   dolu;
   logic                   itme;
   logic                   cekme;
   durum_t                 durum;
   durum_t                 durum_sonraki;
   logic [KW-1:0]          sayac;
   logic [KW-1:0]          sayac_sonraki;
   logic [SW-1:0]          satir;
   logic                   aralik_disi;
   logic                   oku_cek;
   logic                   yaz_cek;

   logic [VO_VERI_BIT-1:0] dizi [DERINLIK];

   logic [OKU_GECIKME-1:0] hat_gec;
   logic [ADRES_BIT-1:0]   hat_adres [OKU_GECIKME];
   logic [VO_VERI_BIT-1:0] hat_veri  [OKU_GECIKME];

   // On a rd+wr collision the write wins; the read is only flagged.
   assign istek        = ram_oku_gecerli_g | ram_yaz_gecerli_g;
   assign dolu         = (sayi == CW'(FIFO_DERINLIK));
   assign itme         = istek & ~dolu;
   assign yeni         = '{yaz: ram_yaz_gecerli_g, adres: ram_adres_g, veri: ram_yaz_veri_g};
   assign sayi_sonraki = sayi + CW'(itme) - CW'(cekme);

   assign satir        = bas.adres[ADRES_BIT-1:SATIR_KAYDIRMA];
   assign aralik_disi  = (satir >= SW'(DERINLIK));
   assign oku_cek      = cekme & ~bas.yaz;
   assign yaz_cek      = cekme & bas.yaz;

   ram_yanitlayici_fifo #(
      .GEN ($bits(istek_t)),
      .DER (FIFO_DERINLIK)
   ) u_fifo (
      .clk_g  (clk_g),
      .resetn (resetn),
      .push   (itme),
      .pop    (cekme),
      .giris  (yeni),
      .cikis  (bas),
      .sayi   (sayi)
   );

   always_ff @(posedge clk_g) begin
      if (!resetn) begin
         durum <= BOS;
         sayac <= '0;
      end else begin
         durum <= durum_sonraki;
         sayac <= sayac_sonraki;
      end
   end

   // The counter leaves YAZIYOR so the next pop lands exactly YAZ_GECIKME edges after a write pop.
   always_comb begin
      durum_sonraki = durum;
      sayac_sonraki = sayac;
      cekme         = 1'b0;
      case (durum)
         BOS: begin
            cekme = (sayi != '0);
            if (cekme && bas.yaz && (YAZ_GECIKME > 1)) begin
               durum_sonraki = YAZIYOR;
               sayac_sonraki = KW'(YAZ_GECIKME-1);
            end
         end
         YAZIYOR: begin
            sayac_sonraki = sayac - KW'(1);
            if (sayac <= KW'(1)) begin
               durum_sonraki = BOS;
               sayac_sonraki = '0;
            end
         end
         default: durum_sonraki = BOS;
      endcase
   end

   always_ff @(posedge clk_g) begin
      if (resetn && yaz_cek && !aralik_disi) dizi[satir[DW-1:0]] <= bas.veri;
   end

   always_ff @(posedge clk_g) begin
      if (!resetn) begin
         hat_gec <= '0;
         for (int i = 0; i < OKU_GECIKME; i++) begin
            hat_adres[i] <= '0;
            hat_veri[i]  <= '0;
         end
      end else begin
         hat_gec[0] <= oku_cek;
         if (oku_cek) begin
            hat_adres[0] <= bas.adres;
            hat_veri[0]  <= aralik_disi ? '0 : dizi[satir[DW-1:0]];
         end
         // Stages load only on a valid beat, so the last stage holds its value between responses.
         for (int i = 1; i < OKU_GECIKME; i++) begin
            hat_gec[i] <= hat_gec[i-1];
            if (hat_gec[i-1]) begin
               hat_adres[i] <= hat_adres[i-1];
               hat_veri[i]  <= hat_veri[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk_g) begin
      if (!resetn) begin
         ram_mesgul_c <= 1'b0;
         hata_c       <= 1'b0;
      end else begin
         ram_mesgul_c <= (sayi_sonraki >= CW'(FIFO_DERINLIK-1));
         hata_c       <= hata_c | (istek & dolu) | (ram_oku_gecerli_g & ram_yaz_gecerli_g)
                         | (cekme & aralik_disi);
      end
   end

   assign ram_oku_gecerli_c = hat_gec[OKU_GECIKME-1];
   assign ram_oku_adres_c   = hat_adres[OKU_GECIKME-1];
   assign ram_oku_veri_c    = hat_veri[OKU_GECIKME-1];
endmodule

// File: tb/tb_ram_yanitlayici.sv
// Bench for ram_yanitlayici: transaction-level timing/data model plus directed and random traffic.

module tb_ram_yanitlayici;
   localparam int AB  = 32;
   localparam int VB  = 128;
   localparam int OKU = 2;
   localparam int YAZ = 3;
   localparam int FD  = 4;
   localparam int INF = 1 << 30;

   logic          clk_g = 1'b0;
   logic          resetn;
   logic [AB-1:0] ram_adres_g;
   logic          ram_oku_gecerli_g;
   logic          ram_yaz_gecerli_g;
   logic [VB-1:0] ram_yaz_veri_g;
   logic [VB-1:0] ram_oku_veri_c;
   logic [AB-1:0] ram_oku_adres_c;
   logic          ram_oku_gecerli_c;
   logic          ram_mesgul_c;
   logic          hata_c;

   always #5 clk_g = ~clk_g;

   ram_yanitlayici dut (
      .clk_g             (clk_g),
      .resetn            (resetn),
      .ram_adres_g       (ram_adres_g),
      .ram_oku_gecerli_g (ram_oku_gecerli_g),
      .ram_yaz_gecerli_g (ram_yaz_gecerli_g),
      .ram_yaz_veri_g    (ram_yaz_veri_g),
      .ram_oku_veri_c    (ram_oku_veri_c),
      .ram_oku_adres_c   (ram_oku_adres_c),
      .ram_oku_gecerli_c (ram_oku_gecerli_c),
      .ram_mesgul_c      (ram_mesgul_c),
      .hata_c            (hata_c)
   );

   // Model: each accepted request gets its pop edge from queue order and write recovery time.
   typedef struct {int pop; bit yaz;} kayit_t;
   typedef struct {int kenar; logic [AB-1:0] adres; logic [VB-1:0] veri;} yanit_t;
   typedef struct {bit oku; bit yaz; logic [AB-1:0] adres; logic [VB-1:0] veri; bit mesgul; bit hata;} vek_t;

   kayit_t        q[$];
   yanit_t        yq[$];
   logic [VB-1:0] mm [256];
   int            t = 0;
   int            bos_kenar = 0;
   int            hata_kenar = INF;
   bit            m_mesgul = 0;
   logic [VB-1:0] son_veri = '0;
   logic [AB-1:0] son_adres = '0;
   int            total = 0;
   int            bad = 0;

   function automatic logic [VB-1:0] rastgele_veri();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk(input string ad, input logic [VB-1:0] act, input logic [VB-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s edge=%0d got=%0h want=%0h", ad, t, act, exp);
      end
   endtask

   task automatic hata_at(input int e);
      if (e < hata_kenar) hata_kenar = e;
   endtask

   task automatic model(input bit rst, input bit oku, input bit yaz,
                        input logic [AB-1:0] a, input logic [VB-1:0] v);
      int            n;
      int            p;
      logic [AB-1:0] s;
      bit            oor;
      yanit_t        y;
      kayit_t        k;
      if (!rst) begin
         q.delete();
         yq.delete();
         bos_kenar  = 0;
         hata_kenar = INF;
         m_mesgul   = 0;
         son_veri   = '0;
         son_adres  = '0;
         return;
      end
      while (q.size() > 0 && q[0].pop < t) void'(q.pop_front());
      n = q.size();
      if (oku || yaz) begin
         if (oku && yaz) hata_at(t);
         if (n < FD) begin
            s   = a >> 7;
            oor = (s >= 256);
            p   = (t + 1 > bos_kenar) ? t + 1 : bos_kenar;
            bos_kenar = p + (yaz ? YAZ : 1);
            if (oor) hata_at(p);
            if (yaz) begin
               if (!oor) mm[s[7:0]] = v;
            end else begin
               y.kenar = p + OKU - 1;
               y.adres = a;
               y.veri  = oor ? '0 : mm[s[7:0]];
               yq.push_back(y);
            end
            k.pop = p;
            k.yaz = yaz;
            q.push_back(k);
         end else begin
            hata_at(t);
         end
      end
      n = 0;
      foreach (q[i]) if (q[i].pop > t) n++;
      m_mesgul = (n >= FD - 1);
   endtask

   task automatic step(input bit rst, input bit oku, input bit yaz,
                       input logic [AB-1:0] a, input logic [VB-1:0] v);
      resetn            = rst;
      ram_oku_gecerli_g = oku;
      ram_yaz_gecerli_g = yaz;
      ram_adres_g       = a;
      ram_yaz_veri_g    = v;
      @(posedge clk_g);
      model(rst, oku, yaz, a, v);
      @(negedge clk_g);
      if (yq.size() > 0 && yq[0].kenar == t) begin
         chk("gecerli", VB'(ram_oku_gecerli_c), VB'(1'b1));
         chk("yanit_veri", ram_oku_veri_c, yq[0].veri);
         chk("yanit_adres", VB'(ram_oku_adres_c), VB'(yq[0].adres));
         son_veri  = yq[0].veri;
         son_adres = yq[0].adres;
         void'(yq.pop_front());
      end else begin
         chk("gecerli", VB'(ram_oku_gecerli_c), VB'(1'b0));
         chk("tutulan_veri", ram_oku_veri_c, son_veri);
         chk("tutulan_adres", VB'(ram_oku_adres_c), VB'(son_adres));
      end
      chk("mesgul", VB'(ram_mesgul_c), VB'(m_mesgul));
      chk("hata", VB'(hata_c), VB'(t >= hata_kenar));
      t++;
   endtask

   task automatic bosta(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic oku(input logic [AB-1:0] a);
      step(1'b1, 1'b1, 1'b0, a, '0);
   endtask

   task automatic yaz(input logic [AB-1:0] a, input logic [VB-1:0] v);
      step(1'b1, 1'b0, 1'b1, a, v);
   endtask

   vek_t          tbl[7];
   logic [VB-1:0] d1;
   logic [VB-1:0] da;
   logic [VB-1:0] dr;
   logic [AB-1:0] ra;
   int            r;

   initial begin
      for (int i = 0; i < 7; i++) begin
         tbl[i].oku    = 1'b0;
         tbl[i].yaz    = 1'b1;
         tbl[i].adres  = AB'((i + 1) * 128);
         tbl[i].veri   = {4{32'hA000_0000 + 32'(i)}};
         tbl[i].mesgul = (i >= 3);
         tbl[i].hata   = (i == 6);
      end
      d1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      da = 128'hAAAA_0000_BBBB_1111_CCCC_2222_DDDD_3333;

      // reset state
      step(1'b0, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b0, 1'b0, '0, '0);

      for (int i = 0; i < 16; i++) begin
         yaz(AB'(i * 128), rastgele_veri());
         bosta(2);
      end
      bosta(2);

      // write then read the same line
      yaz(32'h180, d1);
      bosta(3);
      oku(32'h180);
      bosta(4);

      // read directly behind a write
      yaz(32'h200, da);
      oku(32'h200);
      bosta(6);

      // back-to-back reads
      oku(32'h000);
      oku(32'h080);
      oku(32'h100);
      oku(32'h180);
      bosta(5);

      // overflow from a fresh reset
      step(1'b0, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 7; i++) begin
         step(1'b1, tbl[i].oku, tbl[i].yaz, tbl[i].adres, tbl[i].veri);
         chk("tablo_mesgul", VB'(ram_mesgul_c), VB'(tbl[i].mesgul));
         chk("tablo_hata", VB'(hata_c), VB'(tbl[i].hata));
      end
      bosta(16);
      for (int i = 1; i <= 7; i++) oku(AB'(i * 128));
      bosta(5);

      // out-of-range line
      oku(32'h8000);
      bosta(3);
      yaz(32'h8000, d1);
      oku(32'h8000);
      bosta(6);

      // reset with reads queued behind a write
      step(1'b0, 1'b0, 1'b0, '0, '0);
      yaz(32'h280, da);
      oku(32'h080);
      oku(32'h100);
      oku(32'h180);
      step(1'b0, 1'b0, 1'b0, '0, '0);
      bosta(4);
      oku(32'h280);
      bosta(4);

      // random traffic, busy sometimes ignored
      for (int n = 0; n < 600; n++) begin
         r  = $urandom_range(0, 9);
         ra = AB'($urandom_range(0, 15) * 128 + $urandom_range(0, 127));
         if ($urandom_range(0, 15) == 0) ra = AB'(32'h8000 + $urandom_range(0, 255) * 128);
         dr = rastgele_veri();
         if (r == 9 || (m_mesgul && $urandom_range(0, 3) != 0)) bosta(1);
         else if (r <= 4) step(1'b1, 1'b1, 1'b0, ra, dr);
         else if (r <= 7) step(1'b1, 1'b0, 1'b1, ra, dr);
         else step(1'b1, 1'b1, 1'b1, ra, dr);
      end
      bosta(24);
      chk("yanit_kuyrugu_bos", VB'(yq.size()), VB'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
